// File: rtl/cipher_round_ctrl.sv
// Iterative 16-bit XOR/rotate cipher sequencer: IDLE -> RUN (ROUNDS clocks) -> DONE.
// Optional CIPHER_ZEROIZE_EN clears key, state and out_data on the result handshake.
module cipher_round_ctrl #(
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned ROT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [3:0]  round_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] ROT_AMT    = 4'(ROT % 16);
    localparam logic [3:0] DEC_ROT    = 4'(((ROUNDS - 1) * ROT) % 16);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t      state;
    logic [15:0] st_q;
    logic [15:0] key_q;
    logic        dec_q;
    logic [15:0] st_next;
    logic [15:0] key_next;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] t;
        t = {x, x} << n;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] t;
        t = {x, x} >> n;
        return t[15:0];
    endfunction

    // Decrypt undoes the encrypt round: un-rotate first, then remove the key.
    always_comb begin
        st_next  = st_q;
        key_next = key_q;
        if (dec_q) begin
            st_next  = rotr16(st_q, 4'd1) ^ key_q;
            key_next = rotr16(key_q, ROT_AMT);
        end else begin
            st_next  = rotl16(st_q ^ key_q, 4'd1);
            key_next = rotl16(key_q, ROT_AMT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st_q      <= '0;
            key_q     <= '0;
            dec_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            round_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_q      <= in_data;
                        dec_q     <= in_decrypt;
                        key_q     <= in_decrypt ? rotl16(in_key, DEC_ROT) : in_key;
                        round_idx <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    st_q  <= st_next;
                    key_q <= key_next;
                    if (round_idx == LAST_ROUND) begin
                        out_data  <= st_next;
                        out_valid <= 1'b1;
                        round_idx <= '0;
                        state     <= DONE;
                    end else begin
                        round_idx <= round_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef CIPHER_ZEROIZE_EN
                        st_q      <= '0;
                        key_q     <= '0;
                        out_data  <= '0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    round_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Randomized self-checking bench for cipher_round_ctrl against a round-key-schedule model.
module tb_cipher_round_ctrl;

    localparam int R  = 4;
    localparam int RT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [15:0] in_data, in_key, out_data;
    logic [3:0]  round_idx;

    logic        in_valid_1, in_ready_1, in_decrypt_1, out_valid_1, out_ready_1, busy_1;
    logic [15:0] in_data_1, in_key_1, out_data_1;
    logic [3:0]  round_idx_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cipher_round_ctrl #(.ROUNDS(R), .ROT(RT)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx)
    );

    cipher_round_ctrl #(.ROUNDS(1), .ROT(0)) u_dut_1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
        .in_key(in_key_1), .in_decrypt(in_decrypt_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
        .busy(busy_1), .round_idx(round_idx_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rl(input int x, input int n);
        int m;
        m = n % 16;
        return ((x << m) | (x >> (16 - m))) & 'hFFFF;
    endfunction

    function automatic int rr(input int x, input int n);
        int m;
        m = n % 16;
        return ((x >> m) | (x << (16 - m))) & 'hFFFF;
    endfunction

    // Round r uses key rotl(key, r*rot); decryption applies the inverse rounds in reverse order.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] k,
                                          input bit dec, input int rounds, input int rot);
        int ks[16];
        int s;
        s = int'(d);
        for (int r = 0; r < rounds; r++) ks[r] = rl(int'(k), r * rot);
        if (!dec) begin
            for (int r = 0; r < rounds; r++) s = rl(s ^ ks[r], 1);
        end else begin
            for (int r = rounds - 1; r >= 0; r--) s = rr(s, 1) ^ ks[r];
        end
        return 16'(s);
    endfunction

    function automatic logic [15:0] idle_value(input logic [15:0] res);
`ifdef CIPHER_ZEROIZE_EN
        return 16'h0000;
`else
        return res;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] d, input logic [15:0] k, input logic dec);
        check("in_ready_before_accept", in_ready, 1);
        in_valid   = 1'b1;
        in_data    = d;
        in_key     = k;
        in_decrypt = dec;
        step;
        in_valid   = 1'b0;
        in_data    = 16'($urandom);
        in_key     = 16'($urandom);
        in_decrypt = 1'($urandom);
        check("accept_busy", busy, 1);
        check("accept_in_ready", in_ready, 0);
        check("accept_round_idx", round_idx, 0);
        check("accept_out_valid", out_valid, 0);
    endtask

    task automatic wait_result(input logic [15:0] exp);
        for (int r = 1; r < R; r++) begin
            step;
            check("run_round_idx", round_idx, r);
            check("run_out_valid", out_valid, 0);
        end
        step;
        check("done_out_valid", out_valid, 1);
        check("done_out_data", out_data, exp);
        check("done_round_idx", round_idx, 0);
    endtask

    task automatic release_result(input logic [15:0] exp, input int stall);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            step;
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, exp);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_busy", busy, 0);
        check("hs_out_data", out_data, idle_value(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ct, d, k, e, d2, k2, e2;
        logic        dec;

        rst = 1'b1;
        {in_valid, in_decrypt, out_ready, in_data, in_key} = '0;
        {in_valid_1, in_decrypt_1, out_ready_1, in_data_1, in_key_1} = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_round_idx", round_idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step;
        check("post_rst_in_ready", in_ready, 1);

        // ROUNDS=1, ROT=0 instance: one-cycle latency, round-trips back.
        in_valid_1 = 1'b1; in_data_1 = 16'hB309; in_key_1 = 16'h1234; in_decrypt_1 = 1'b0;
        step;
        in_valid_1 = 1'b0;
        check("r1_accept_out_valid", out_valid_1, 0);
        check("r1_accept_busy", busy_1, 1);
        step;
        check("r1_out_valid", out_valid_1, 1);
        check("r1_out_data", out_data_1, 16'h427B);
        out_ready_1 = 1'b1;
        step;
        out_ready_1 = 1'b0;
        check("r1_hs_in_ready", in_ready_1, 1);
        in_valid_1 = 1'b1; in_data_1 = 16'h427B; in_decrypt_1 = 1'b1;
        step;
        in_valid_1 = 1'b0;
        step;
        check("r1_dec_out_data", out_data_1, 16'hB309);
        out_ready_1 = 1'b1;
        step;
        out_ready_1 = 1'b0;

        // Defaults: encrypt then decrypt with same key.
        ct = model(16'hB309, 16'h1234, 1'b0, R, RT);
        start_op(16'hB309, 16'h1234, 1'b0);
        wait_result(ct);
        release_result(ct, 0);
        start_op(ct, 16'h1234, 1'b1);
        wait_result(model(ct, 16'h1234, 1'b1, R, RT));
        check("roundtrip_b309", out_data, 16'hB309);
        release_result(16'hB309, 0);

        // Backpressure with in_valid pulses while in DONE.
        start_op(16'h5A5A, 16'hC3E1, 1'b0);
        e = model(16'h5A5A, 16'hC3E1, 1'b0, R, RT);
        wait_result(e);
        release_result(e, 10);

        // Reset during RUN round 2 aborts the operation.
        start_op(16'hB309, 16'h1234, 1'b0);
        step;
        step;
        check("mid_round_idx", round_idx, 2);
        #2 rst = 1'b1;
        #1;
        check("abort_out_data", out_data, 0);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_round_idx", round_idx, 0);
        check("abort_in_ready", in_ready, 1);
        #1 rst = 1'b0;
        step;
        start_op(16'hB309, 16'h1234, 1'b0);
        wait_result(ct);
        release_result(ct, 1);

        // in_valid held across the handshake: second word waits for the first IDLE cycle.
        d = 16'($urandom); k = 16'($urandom);
        d2 = 16'($urandom); k2 = 16'($urandom);
        e = model(d, k, 1'b0, R, RT);
        e2 = model(d2, k2, 1'b1, R, RT);
        start_op(d, k, 1'b0);
        wait_result(e);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d2; in_key = k2; in_decrypt = 1'b1;
        step;
        out_ready = 1'b0;
        check("chain_not_accepted_busy", busy, 0);
        check("chain_idle_in_ready", in_ready, 1);
        check("chain_idle_out_data", out_data, idle_value(e));
        start_op(d2, k2, 1'b1);
        wait_result(e2);
        release_result(e2, 2);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            d   = 16'($urandom);
            k   = 16'($urandom);
            dec = 1'($urandom);
            e   = model(d, k, dec, R, RT);
            start_op(d, k, dec);
            wait_result(e);
            release_result(e, int'($urandom_range(0, 3)));
            if (!dec) begin
                start_op(e, k, 1'b1);
                wait_result(model(e, k, 1'b1, R, RT));
                check("rand_roundtrip", out_data, d);
                release_result(d, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_round_ctrl.md
Name: cipher_round_ctrl

Overview:
- Sequencing controller for the 16-bit XOR cipher datapath.
- Accepts a plaintext/ciphertext word plus key over a valid/ready handshake and runs ROUNDS iterative rounds, one per clock.
- Each round is XOR with a rotating round key, then a 1-bit rotate.
- Presents the result on a held valid/ready output that feeds the seg_decoder/display path.

Parameters:
- ROUNDS, 4: number of rounds; legal range 1..15.
- ROT, 3: round-key left-rotate amount per round; legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word and key are valid.
- in_ready  out  1  controller can accept input; high only in IDLE.
- in_data  in  16  plaintext (encrypt) or ciphertext (decrypt).
- in_key  in  16  raw key.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with in_data.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  result word.
- busy  out  1  high in RUN or DONE.
- round_idx  out  4  current round number; 0 outside RUN.

Behaviour:
- Reset, asynchronous, from any state:
  - state = IDLE; state/key/round registers = 0.
  - out_data = 16'h0000, out_valid = 0, busy = 0, round_idx = 0.
  - in_ready = 1 while in IDLE, including immediately after reset deassertion.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No partial result is ever signalled.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a rising edge: latch in_data into the state register and latch mode. Go to RUN with round = 0.
  - Initial round key on acceptance:
    - Encrypt: k = in_key.
    - Decrypt: k = rotl(in_key, ((ROUNDS-1)*ROT) mod 16).
- RUN:
  - in_ready = 0; one round per clock.
  - Encrypt round: state <= rotl(state ^ k, 1); k <= rotl(k, ROT).
  - Decrypt round: state <= rotr(state, 1) ^ k; k <= rotr(k, ROT).
  - All rotates are modulo 16. The decrypt sequence is the exact inverse of the encrypt sequence for the same key.
  - round_idx shows the round being computed.
  - After the round with index ROUNDS-1, go to DONE.
- DONE:
  - out_valid = 1; out_data = final state.
  - out_data and out_valid are held stable while out_ready = 0, for any number of cycles.
  - On out_ready, go to IDLE next edge.
- Latency: input accepted at edge T, out_valid high after edge T+ROUNDS.
- Throughput: one word per ROUNDS+2 cycles minimum.
- Simultaneous events:
  - in_valid while in RUN or DONE is ignored; the upstream producer holds it.
  - The out_ready handshake and a new in_valid in the same cycle do not overlap. The new input is accepted no earlier than the first IDLE cycle (one bubble).
- out_data in IDLE: holds the last result (see optional feature).
- in_key/in_data changes outside the accept edge have no effect.
- round_idx = 0 in IDLE/DONE.
- No combinational path from in_valid or out_ready to any output.

Optional Feature:
- Macro: CIPHER_ZEROIZE_EN.
- Defined:
  - On the DONE→IDLE handshake edge, the key register, state register and out_data are cleared to 16'h0000.
  - out_data therefore reads 0 in IDLE.
- Undefined:
  - Registers retain their values.
  - out_data holds the last result until the next DONE.

Test Plan:
1. ROUNDS=1, ROT=0, encrypt, in_data=16'hB309, in_key=16'h1234 -> out_valid high 1 cycle after accept, out_data=16'h427B.
2. Defaults, encrypt 16'hB309 with key 16'h1234, then decrypt that result with the same key -> out_data=16'hB309; out_valid rises exactly 4 cycles after each accept; round_idx steps 0,1,2,3.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> out_valid=1, out_data stable, in_ready=0, no input consumed; out_ready=1 -> IDLE next cycle, in_ready=1.
4. Assert rst during RUN round 2 -> outputs immediately at reset values (out_data=0, busy=0, out_valid=0); after release, a fresh encrypt of 16'hB309 completes correctly.
5. in_valid held high across the DONE handshake -> second word accepted on the first IDLE cycle, not on the handshake edge.
6. CIPHER_ZEROIZE_EN defined vs undefined -> after handshake, out_data=16'h0000 vs retained result.
